// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-cycle load/hold/flush decisions for the
// five pipeline registers, plus saturating stall/bubble/flush event counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             im_wait,
  input  logic             dm_wait,
  input  logic             memread_ex,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_use_id,
  input  logic             rs2_use_id,
  input  logic             branch_taken_ex,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exme_we,
  output logic             mewb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pc_redirect,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_WAIT_FL = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_q;
  state_t state_d;

  logic mem_wait;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic flush_pending;
  logic do_flush;
  logic do_bubble;

  assign mem_wait = im_wait | dm_wait;
  assign rs1_hit  = rs1_use_id & (rs1_id == rd_ex);
  assign rs2_hit  = rs2_use_id & (rs2_id == rd_ex);
  assign load_use = memread_ex & (rd_ex != 5'd0) & (rs1_hit | rs2_hit);

  // A branch seen during a stall is parked in WAIT_FL and replayed once memory is ready.
  assign flush_pending = (state_q == ST_WAIT_FL);
  assign do_flush      = ~mem_wait & (branch_taken_ex | flush_pending);
  assign do_bubble     = ~mem_wait & ~do_flush & load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (mem_wait && branch_taken_ex) begin
          state_d = ST_WAIT_FL;
        end else if (mem_wait) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mem_wait) begin
          state_d = ST_RUN;
        end else if (branch_taken_ex) begin
          state_d = ST_WAIT_FL;
        end
      end
      ST_WAIT_FL: begin
        if (!mem_wait) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exme_we     = 1'b1;
    mewb_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pc_redirect = 1'b0;
    if (mem_wait) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      exme_we = 1'b0;
      mewb_we = 1'b0;
    end else if (do_flush) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      pc_redirect = 1'b1;
    end else if (do_bubble) begin
      // Hold PC and IF/ID; the NOP in ID/EX clears the hazard next cycle.
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (mem_wait && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
    end else if (do_bubble && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      flush_cnt <= '0;
    end else if (do_flush && (flush_cnt != CNT_MAX)) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl; a full-width and a 4-bit
// counter instance share stimulus and are checked against an abstract model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       im_wait = 1'b0, dm_wait = 1'b0, memread_ex = 1'b0;
  logic [4:0] rd_ex = '0, rs1_id = '0, rs2_id = '0;
  logic       rs1_use_id = 1'b0, rs2_use_id = 1'b0;
  logic       branch_taken_ex = 1'b0, cnt_clr = 1'b0;

  logic        pc_we, ifid_we, idex_we, exme_we, mewb_we, ifid_flush, idex_flush, pc_redirect;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
  logic        pc_we4, ifid_we4, idex_we4, exme_we4, mewb_we4, ifid_flush4, idex_flush4, pc_redirect4;
  logic [1:0]  state_o4;
  logic [3:0]  stall_cnt4, bubble_cnt4, flush_cnt4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .im_wait(im_wait), .dm_wait(dm_wait),
    .memread_ex(memread_ex), .rd_ex(rd_ex), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_use_id(rs1_use_id), .rs2_use_id(rs2_use_id),
    .branch_taken_ex(branch_taken_ex), .cnt_clr(cnt_clr),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exme_we(exme_we),
    .mewb_we(mewb_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pc_redirect(pc_redirect), .state_o(state_o),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .im_wait(im_wait), .dm_wait(dm_wait),
    .memread_ex(memread_ex), .rd_ex(rd_ex), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_use_id(rs1_use_id), .rs2_use_id(rs2_use_id),
    .branch_taken_ex(branch_taken_ex), .cnt_clr(cnt_clr),
    .pc_we(pc_we4), .ifid_we(ifid_we4), .idex_we(idex_we4), .exme_we(exme_we4),
    .mewb_we(mewb_we4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
    .pc_redirect(pc_redirect4), .state_o(state_o4),
    .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4), .flush_cnt(flush_cnt4)
  );

  // Model: "memory stalled" and "branch owed" flags plus plain integer event counts.
  bit     m_stalled = 0, m_pending = 0;
  longint m_stall = 0, m_bubble = 0, m_flush = 0;
  longint m4_stall = 0, m4_bubble = 0, m4_flush = 0;
  bit     n_stalled, n_pending;
  longint n_stall, n_bubble, n_flush, n4_stall, n4_bubble, n4_flush;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint bump(input longint v, input bit inc, input longint maxv);
    if (cnt_clr) return 0;
    if (inc && v < maxv) return v + 1;
    return v;
  endfunction

  task automatic modelReset();
    m_stalled = 0; m_pending = 0;
    m_stall = 0; m_bubble = 0; m_flush = 0;
    m4_stall = 0; m4_bubble = 0; m4_flush = 0;
  endtask

  task automatic checkNow();
    bit mw, lu, fl, bb;
    logic [7:0] exp_ctl;
    logic [1:0] exp_st;
    mw = im_wait | dm_wait;
    lu = memread_ex && (rd_ex != 0) &&
         ((rs1_use_id && rs1_id == rd_ex) || (rs2_use_id && rs2_id == rd_ex));
    fl = !mw && (m_pending || branch_taken_ex);
    bb = !mw && !fl && lu;
    if (mw)      exp_ctl = 8'b00000_000;
    else if (fl) exp_ctl = 8'b11111_111;
    else if (bb) exp_ctl = 8'b00111_010;
    else         exp_ctl = 8'b11111_000;
    exp_st = !m_stalled ? 2'd0 : (m_pending ? 2'd2 : 2'd1);
    checkOutput("ctl", 64'({pc_we, ifid_we, idex_we, exme_we, mewb_we, ifid_flush, idex_flush, pc_redirect}), 64'(exp_ctl));
    checkOutput("ctl4", 64'({pc_we4, ifid_we4, idex_we4, exme_we4, mewb_we4, ifid_flush4, idex_flush4, pc_redirect4}), 64'(exp_ctl));
    checkOutput("state", 64'(state_o), 64'(exp_st));
    checkOutput("state4", 64'(state_o4), 64'(exp_st));
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    checkOutput("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
    checkOutput("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    checkOutput("stall_cnt4", 64'(stall_cnt4), 64'(m4_stall));
    checkOutput("bubble_cnt4", 64'(bubble_cnt4), 64'(m4_bubble));
    checkOutput("flush_cnt4", 64'(flush_cnt4), 64'(m4_flush));
    n_stalled = mw;
    n_pending = mw && (m_pending || branch_taken_ex);
    n_stall   = bump(m_stall, mw, 64'hFFFF_FFFF);
    n_bubble  = bump(m_bubble, bb, 64'hFFFF_FFFF);
    n_flush   = bump(m_flush, fl, 64'hFFFF_FFFF);
    n4_stall  = bump(m4_stall, mw, 15);
    n4_bubble = bump(m4_bubble, bb, 15);
    n4_flush  = bump(m4_flush, fl, 15);
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance model at the rising edge.
  task automatic applyStimulus(input bit im, input bit dm, input bit mr, input logic [4:0] rd,
                               input logic [4:0] r1, input logic [4:0] r2, input bit u1,
                               input bit u2, input bit br, input bit clr);
    im_wait = im; dm_wait = dm; memread_ex = mr; rd_ex = rd;
    rs1_id = r1; rs2_id = r2; rs1_use_id = u1; rs2_use_id = u2;
    branch_taken_ex = br; cnt_clr = clr;
    #1;
    checkNow();
    @(posedge clk);
    if (rst_n) begin
      m_stalled = n_stalled; m_pending = n_pending;
      m_stall = n_stall; m_bubble = n_bubble; m_flush = n_flush;
      m4_stall = n4_stall; m4_bubble = n4_bubble; m4_flush = n4_flush;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit prev_br;
    bit br;
    modelReset();
    #2;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Load-use on rs1, then the same with rd_ex=0, then via rs2.
    applyStimulus(0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
    idle(1);
    applyStimulus(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 5'd9, 5'd1, 5'd9, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 5'd9, 5'd9, 5'd9, 0, 0, 0, 0);

    // Three-cycle data memory stall.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Branch on cycle 2 of a 4-cycle instruction stall, with a second pulse later.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Branch and load-use together.
    applyStimulus(0, 0, 1, 5'd7, 5'd7, 5'd7, 1, 1, 1, 0);
    idle(1);

    // Saturate the 4-bit counters, then clear during an active stall.
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Reset while a flush is pending drops it.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(2);

    // Random traffic with small register numbers so hazards are frequent.
    prev_br = 0;
    for (int i = 0; i < 600; i++) begin
      br = !prev_br && ($urandom_range(0, 5) == 0);
      applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    br, $urandom_range(0, 24) == 0);
      prev_br = br;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
